cu_seq: RTL and testbench
=========================

Name: cu_seq

Overview:
- Parametrised multi-cycle successor to the combinational opcode decoder.
- Owns the program counter (PC) and instruction register (IR).
- Fetches instructions from the synchronous-read ROM and sequences decode, execute and writeback through an FSM.
- Drives RAM read/write and ALU enable/op strobes per state, waits on a memory-ready handshake at writeback, and supports NOP, JMP and HLT in addition to MOV and the ALU ops.

Parameters:
- ADDR_W, 8, ROM address / PC width.
- INSTR_W, 16, instruction width. Must be ≥ OPC_W+ADDR_W.
- OPC_W, 4, opcode field width. Field is instr[INSTR_W-1 -: OPC_W].
- ALU_OP_W, 4, ALU op code width.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level/pulse; leaves IDLE.
- mem_ready  in  1  RAM/ALU writeback accept, sampled in WB.
- rom_data  in  INSTR_W  ROM data_out, valid one cycle after rom_read.
- rom_addr  out  ADDR_W  ROM address, equals pc.
- rom_read  out  1  ROM read enable.
- ram_read  out  1  RAM read strobe.
- ram_write  out  1  RAM write strobe.
- alu_enable  out  1  ALU enable.
- alu_op  out  ALU_OP_W  ALU operation.
- pc  out  ADDR_W  program counter.
- ir  out  INSTR_W  instruction register.
- busy  out  1  high in FETCH, LOAD, EXEC, WB.
- halted  out  1  high in HALT.
- illegal  out  1  sticky: unknown opcode seen.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset (async, rst_n=0): state=IDLE, pc=0, ir=0, illegal=0. All strobes 0, alu_op=0, busy=0, halted=0. Applies mid-instruction, with outputs cleared immediately.
- Strobe outputs are decoded combinationally from state and ir opcode. They are 0 in every state/opcode not listed below.
- IDLE:
  - start=1 -> FETCH.
  - start=0 -> stay.
- FETCH:
  - rom_read=1, rom_addr=pc.
  - -> LOAD.
- LOAD:
  - ir<=rom_data, pc<=pc+1 (mod 2^ADDR_W; 2^ADDR_W-1 wraps to 0).
  - -> EXEC.
- EXEC, by ir opcode:
  - 0000 NOP: -> FETCH.
  - 0001 MOV: ram_read=1; -> WB.
  - ALU ops: ram_read=1, alu_op per map below; -> WB.
  - 1100 JMP: pc<=ir[ADDR_W-1:0]; -> FETCH.
  - 1111 HLT: -> HALT.
  - 1101, 1110: illegal<=1, treated as NOP; -> FETCH.
- ALU opcode -> alu_op map:
  - ADD 0010->0001
  - SUB 0011->0010
  - AND 0100->0011
  - OR 0101->0100
  - XOR 0110->0101
  - NOT 0111->0110
  - SHL 1000->0111
  - SHR 1001->1000
  - LT 1010->1001
  - EQ 1011->1010
- WB:
  - MOV: ram_write=1.
  - ALU ops: alu_enable=1 and alu_op held.
  - Strobes stay asserted every cycle mem_ready=0.
  - mem_ready=1 -> FETCH. Strobes drop the following cycle.
- HALT:
  - halted=1, all strobes 0.
  - Stays until reset; start is ignored.
- start is ignored outside IDLE.
- Latencies with mem_ready=1:
  - MOV/ALU: 4 cycles.
  - NOP/JMP/illegal: 3 cycles.
  - HLT: 3 cycles to HALT.
- JMP to its own address loops forever. No special handling.
- OPC_W>4: opcodes outside the above list are illegal.

Test Plan:
- Reset then start with ROM[0]=0x2000 (ADD), mem_ready=1 -> rom_read at cycle 1, ir=0x2000 and pc=1 after LOAD. ram_read=1 and alu_op=0001 in EXEC; alu_enable=1 in WB; FETCH at pc=1 on cycle 5.
- ROM[0]=0x1000 (MOV), mem_ready held 0 for 3 WB cycles -> ram_write=1 for exactly 4 cycles, then FETCH. No other strobes in WB.
- ROM[0]=0xC0FE (JMP) -> pc=0xFE after EXEC, next rom_addr=0xFE. Then ROM[0xFF]=0x0000 with pc=0xFF -> pc wraps to 0x00 after LOAD.
- ROM[0]=0xD000 then ROM[1]=0xF000 -> illegal=1 sticky from EXEC of first instruction. halted=1 after second; busy=0; toggling start leaves HALT unchanged.
- Assert rst_n=0 asynchronously mid-WB of an ALU op -> alu_enable, ram_read and busy go 0 without a clock edge. pc=0, ir=0, state IDLE; after release, no fetch until start.
- Sweep all ten ALU opcodes -> alu_op matches the map above in EXEC and WB, ram_read=1 only in EXEC.

Source files
------------

// File: rtl/cu_seq_if.sv
// cu_seq_if: ROM fetch, RAM strobe and ALU control bus between the sequencer and its datapath.
interface cu_seq_if #(
    parameter int ADDR_W   = 8,
    parameter int INSTR_W  = 16,
    parameter int ALU_OP_W = 4
);
    logic [ADDR_W-1:0]   rom_addr;
    logic                rom_read;
    logic [INSTR_W-1:0]  rom_data;
    logic                ram_read;
    logic                ram_write;
    logic                alu_enable;
    logic [ALU_OP_W-1:0] alu_op;
    logic                mem_ready;

    modport master (
        output rom_addr, rom_read, ram_read, ram_write, alu_enable, alu_op,
        input  rom_data, mem_ready
    );

    modport slave (
        input  rom_addr, rom_read, ram_read, ram_write, alu_enable, alu_op,
        output rom_data, mem_ready
    );
endinterface

// File: rtl/cu_seq.sv
// cu_seq: multi-cycle fetch/decode/execute/writeback sequencer owning pc and ir.
module cu_seq #(
    parameter int ADDR_W   = 8,
    parameter int INSTR_W  = 16,
    parameter int OPC_W    = 4,
    parameter int ALU_OP_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    cu_seq_if.master           bus,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] ir,
    output logic               busy,
    output logic               halted,
    output logic               illegal
);
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, EXEC, WB, HALT} state_t;

    state_t state, state_nx;
    logic [OPC_W-1:0] opc;
    logic is_nop, is_mov, is_alu, is_jmp, is_hlt, is_ill;
    logic [ALU_OP_W-1:0] alu_code;

    assign opc      = ir[INSTR_W-1 -: OPC_W];
    assign is_nop   = opc == OPC_W'(0);
    assign is_mov   = opc == OPC_W'(1);
    assign is_alu   = opc >= OPC_W'(2) && opc <= OPC_W'(11);
    assign is_jmp   = opc == OPC_W'(12);
    assign is_hlt   = opc == OPC_W'(15);
    assign is_ill   = !(is_nop || is_mov || is_alu || is_jmp || is_hlt);
    // ALU opcodes 0010..1011 map onto alu_op 0001..1010
    assign alu_code = ALU_OP_W'(opc - OPC_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc      <= '0;
            ir      <= '0;
            illegal <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == LOAD) begin
                ir <= bus.rom_data;
                pc <= pc + ADDR_W'(1);
            end else if (state == EXEC && is_jmp) begin
                pc <= ir[ADDR_W-1:0];
            end
            if (state == EXEC && is_ill)
                illegal <= 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? FETCH : IDLE;
            FETCH:   state_nx = LOAD;
            LOAD:    state_nx = EXEC;
            EXEC:    state_nx = is_hlt ? HALT : (is_mov || is_alu) ? WB : FETCH;
            WB:      state_nx = bus.mem_ready ? FETCH : WB;
            default: state_nx = state;
        endcase
        bus.rom_addr   = pc;
        bus.rom_read   = state == FETCH;
        bus.ram_read   = state == EXEC && (is_mov || is_alu);
        bus.ram_write  = state == WB && is_mov;
        bus.alu_enable = state == WB && is_alu;
        bus.alu_op     = ((state == EXEC || state == WB) && is_alu) ? alu_code : '0;
        busy           = state == FETCH || state == LOAD || state == EXEC || state == WB;
        halted         = state == HALT;
    end
endmodule

// File: tb/tb_cu_seq.sv
// tb_cu_seq: scoreboarded per-cycle check of cu_seq strobes, pc and status against a ROM model.
module tb_cu_seq;
    typedef struct {
        logic [18:0] v;
        bit          st;
        bit          mr;
    } exp_t;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        start = 0;
    logic [7:0]  pc;
    logic [15:0] ir;
    logic        busy, halted, illegal;
    logic [15:0] rom [256];
    exp_t        sb[$];
    exp_t        e;
    int          n_tests = 0;
    int          n_fail = 0;

    cu_seq_if #(.ADDR_W(8), .INSTR_W(16), .ALU_OP_W(4)) bus ();

    cu_seq #(.ADDR_W(8), .INSTR_W(16), .OPC_W(4), .ALU_OP_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
        .pc(pc), .ir(ir), .busy(busy), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (bus.rom_read) bus.rom_data <= rom[bus.rom_addr];

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    function automatic logic [18:0] obs();
        return {bus.rom_read, bus.ram_read, bus.ram_write, bus.alu_enable, bus.alu_op,
                busy, halted, illegal, pc};
    endfunction

    function automatic logic [18:0] ev(bit rr, bit rd, bit wr, bit ae, logic [3:0] op,
                                       bit bz, bit ht, bit il, logic [7:0] p);
        return {rr, rd, wr, ae, op, bz, ht, il, p};
    endfunction

    task automatic push(logic [18:0] v, bit st, bit mr);
        sb.push_back('{v, st, mr});
    endtask

    task automatic do_reset();
        rst_n = 0;
        start = 0;
        bus.mem_ready = 1;
        foreach (rom[i]) rom[i] = '0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1;
    endtask

    task automatic test_reset();
        int c = 0;
        do_reset();
        rst_n = 0;
        #1;
        n_tests++;
        if (obs() !== '0 || ir !== '0) begin
            n_fail++;
            $display("FAIL reset got %h ir %h exp 0 ir 0", obs(), ir);
        end
        #1 rst_n = 1;
        repeat (3) push('0, 0, 1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk); #1;
            n_tests++;
            if (obs() !== e.v) begin
                n_fail++;
                $display("FAIL reset_idle cyc%0d got %h exp %h", c, obs(), e.v);
            end
            start = e.st; bus.mem_ready = e.mr; c++;
        end
    endtask

    task automatic test_add();
        int c = 0;
        do_reset();
        rom[0] = 16'h2000;
        push(ev(1,0,0,0,4'h0,1,0,0,8'h00), 0, 1);
        push(ev(0,0,0,0,4'h0,1,0,0,8'h00), 0, 1);
        push(ev(0,1,0,0,4'h1,1,0,0,8'h01), 0, 1);
        push(ev(0,0,0,1,4'h1,1,0,0,8'h01), 0, 1);
        push(ev(1,0,0,0,4'h0,1,0,0,8'h01), 0, 1);
        start = 1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk); #1;
            n_tests++;
            if (obs() !== e.v) begin
                n_fail++;
                $display("FAIL add cyc%0d got %h exp %h", c, obs(), e.v);
            end
            start = e.st; bus.mem_ready = e.mr; c++;
        end
        n_tests++;
        if (ir !== 16'h2000 || bus.rom_addr !== 8'h01) begin
            n_fail++;
            $display("FAIL add_ir got ir %h addr %h exp ir 2000 addr 01", ir, bus.rom_addr);
        end
    endtask

    task automatic test_mov_wait();
        int c = 0;
        do_reset();
        rom[0] = 16'h1000;
        bus.mem_ready = 0;
        push(ev(1,0,0,0,4'h0,1,0,0,8'h00), 0, 0);
        push(ev(0,0,0,0,4'h0,1,0,0,8'h00), 0, 0);
        push(ev(0,1,0,0,4'h0,1,0,0,8'h01), 0, 0);
        push(ev(0,0,1,0,4'h0,1,0,0,8'h01), 0, 0);
        push(ev(0,0,1,0,4'h0,1,0,0,8'h01), 0, 0);
        push(ev(0,0,1,0,4'h0,1,0,0,8'h01), 0, 0);
        push(ev(0,0,1,0,4'h0,1,0,0,8'h01), 0, 1);
        push(ev(1,0,0,0,4'h0,1,0,0,8'h01), 0, 1);
        start = 1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk); #1;
            n_tests++;
            if (obs() !== e.v) begin
                n_fail++;
                $display("FAIL mov_wait cyc%0d got %h exp %h", c, obs(), e.v);
            end
            start = e.st; bus.mem_ready = e.mr; c++;
        end
    endtask

    task automatic test_jmp_wrap();
        int c = 0;
        do_reset();
        rom[0] = 16'hC0FE;
        push(ev(1,0,0,0,4'h0,1,0,0,8'h00), 0, 1);
        push(ev(0,0,0,0,4'h0,1,0,0,8'h00), 0, 1);
        push(ev(0,0,0,0,4'h0,1,0,0,8'h01), 0, 1);
        push(ev(1,0,0,0,4'h0,1,0,0,8'hFE), 0, 1);
        push(ev(0,0,0,0,4'h0,1,0,0,8'hFE), 0, 1);
        push(ev(0,0,0,0,4'h0,1,0,0,8'hFF), 0, 1);
        push(ev(1,0,0,0,4'h0,1,0,0,8'hFF), 0, 1);
        push(ev(0,0,0,0,4'h0,1,0,0,8'hFF), 0, 1);
        push(ev(0,0,0,0,4'h0,1,0,0,8'h00), 0, 1);
        push(ev(1,0,0,0,4'h0,1,0,0,8'h00), 0, 1);
        start = 1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk); #1;
            n_tests++;
            if (obs() !== e.v) begin
                n_fail++;
                $display("FAIL jmp_wrap cyc%0d got %h exp %h", c, obs(), e.v);
            end
            if (c == 3) begin
                n_tests++;
                if (bus.rom_addr !== 8'hFE) begin
                    n_fail++;
                    $display("FAIL jmp_addr got %h exp fe", bus.rom_addr);
                end
            end
            start = e.st; bus.mem_ready = e.mr; c++;
        end
    endtask

    task automatic test_illegal_halt();
        int c = 0;
        do_reset();
        rom[0] = 16'hD000;
        rom[1] = 16'hF000;
        push(ev(1,0,0,0,4'h0,1,0,0,8'h00), 0, 1);
        push(ev(0,0,0,0,4'h0,1,0,0,8'h00), 0, 1);
        push(ev(0,0,0,0,4'h0,1,0,0,8'h01), 0, 1);
        push(ev(1,0,0,0,4'h0,1,0,1,8'h01), 0, 1);
        push(ev(0,0,0,0,4'h0,1,0,1,8'h01), 0, 1);
        push(ev(0,0,0,0,4'h0,1,0,1,8'h02), 0, 1);
        push(ev(0,0,0,0,4'h0,0,1,1,8'h02), 1, 1);
        push(ev(0,0,0,0,4'h0,0,1,1,8'h02), 0, 1);
        push(ev(0,0,0,0,4'h0,0,1,1,8'h02), 1, 1);
        push(ev(0,0,0,0,4'h0,0,1,1,8'h02), 0, 1);
        start = 1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk); #1;
            n_tests++;
            if (obs() !== e.v) begin
                n_fail++;
                $display("FAIL illegal_halt cyc%0d got %h exp %h", c, obs(), e.v);
            end
            start = e.st; bus.mem_ready = e.mr; c++;
        end
    endtask

    task automatic test_async_reset();
        int c = 0;
        do_reset();
        rom[0] = 16'h3000;
        bus.mem_ready = 0;
        push(ev(1,0,0,0,4'h0,1,0,0,8'h00), 0, 0);
        push(ev(0,0,0,0,4'h0,1,0,0,8'h00), 0, 0);
        push(ev(0,1,0,0,4'h2,1,0,0,8'h01), 0, 0);
        push(ev(0,0,0,1,4'h2,1,0,0,8'h01), 0, 0);
        start = 1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk); #1;
            n_tests++;
            if (obs() !== e.v) begin
                n_fail++;
                $display("FAIL async_pre cyc%0d got %h exp %h", c, obs(), e.v);
            end
            start = e.st; bus.mem_ready = e.mr; c++;
        end
        #2 rst_n = 0;
        #1;
        n_tests++;
        if (obs() !== '0 || ir !== '0) begin
            n_fail++;
            $display("FAIL async_clear got %h ir %h exp 0 ir 0", obs(), ir);
        end
        #2 rst_n = 1;
        bus.mem_ready = 1;
        push('0, 0, 1);
        push('0, 0, 1);
        push('0, 1, 1);
        push(ev(1,0,0,0,4'h0,1,0,0,8'h00), 0, 1);
        c = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk); #1;
            n_tests++;
            if (obs() !== e.v) begin
                n_fail++;
                $display("FAIL async_post cyc%0d got %h exp %h", c, obs(), e.v);
            end
            start = e.st; bus.mem_ready = e.mr; c++;
        end
    endtask

    task automatic test_alu_sweep();
        logic [3:0] alu_map [10] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA};
        for (int k = 0; k < 10; k++) begin
            logic [3:0] opc;
            int c = 0;
            opc = 4'(k + 2);
            do_reset();
            rom[0] = {opc, 12'h000};
            push(ev(1,0,0,0,4'h0,1,0,0,8'h00), 0, 1);
            push(ev(0,0,0,0,4'h0,1,0,0,8'h00), 0, 1);
            push(ev(0,1,0,0,alu_map[k],1,0,0,8'h01), 0, 1);
            push(ev(0,0,0,1,alu_map[k],1,0,0,8'h01), 0, 1);
            push(ev(1,0,0,0,4'h0,1,0,0,8'h01), 0, 1);
            start = 1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                @(posedge clk); #1;
                n_tests++;
                if (obs() !== e.v) begin
                    n_fail++;
                    $display("FAIL alu_sweep opc%h cyc%0d got %h exp %h", opc, c, obs(), e.v);
                end
                start = e.st; bus.mem_ready = e.mr; c++;
            end
        end
    endtask

    initial begin
        bus.mem_ready = 1;
        test_reset();
        test_add();
        test_mov_wait();
        test_jmp_wrap();
        test_illegal_halt();
        test_async_reset();
        test_alu_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
